// File: rtl/cpstr_wordasm_if.sv
// Stream bundle between the control port de-escaper, the word assembler and the command decoder.
// master drives the byte/escape streams and the downstream ready; slave is the assembler.
interface cpstr_wordasm_if #(
  parameter int WORD_BYTES = 4,
  parameter int ERR_W      = 8
);
  logic [7:0]              i_data;
  logic                    i_valid;
  logic                    o_ready;
  logic [7:0]              i_esc_data;
  logic                    i_esc_valid;
  logic                    o_esc_ready;
  logic [8*WORD_BYTES-1:0] o_word;
  logic                    o_sof;
  logic                    o_valid;
  logic                    i_ready;
  logic [ERR_W-1:0]        o_err_cnt;

  modport master (
    output i_data, i_valid, i_esc_data, i_esc_valid, i_ready,
    input  o_ready, o_esc_ready, o_word, o_sof, o_valid, o_err_cnt
  );

  modport slave (
    input  i_data, i_valid, i_esc_data, i_esc_valid, i_ready,
    output o_ready, o_esc_ready, o_word, o_sof, o_valid, o_err_cnt
  );
endinterface

// File: rtl/cpstr_wordasm.sv
// Packs de-escaped control port bytes little-endian into words, framed by the SOF escape.
// Optional protocol error counter enabled by macro CPSTR_WORDASM_ERRCNT_EN.
module cpstr_wordasm #(
  parameter int         WORD_BYTES = 4,
  parameter logic [7:0] ESC_SOF    = 8'h53,
  parameter int         ERR_W      = 8
) (
  input  logic              clk,
  input  logic              rst,
  cpstr_wordasm_if.slave    bus
);

  localparam int              CW   = $clog2(WORD_BYTES);
  localparam logic [CW-1:0]   LAST = CW'(WORD_BYTES - 1);

  logic [8*(WORD_BYTES-1)-1:0] asm_data_r;
  logic [CW-1:0]               cnt_r;
  logic                        sof_pend_r;
  logic [8*WORD_BYTES-1:0]     out_word_r;
  logic                        out_sof_r;
  logic                        out_valid_r;

  logic ready_s;
  logic byte_acc_s;
  logic esc_acc_s;
  logic is_sof_s;
  logic load_s;

  // Handshake decode; escapes win over bytes and a full output only admits a completing byte while it drains
  always_comb begin
    ready_s    = !bus.i_esc_valid && ((cnt_r != LAST) || !out_valid_r || bus.i_ready);
    esc_acc_s  = bus.i_esc_valid;
    byte_acc_s = bus.i_valid && ready_s;
    is_sof_s   = (bus.i_esc_data == ESC_SOF);
    load_s     = byte_acc_s && (cnt_r == LAST);
  end

  // Assembly lanes, byte counter and pending start-of-frame flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      asm_data_r <= '0;
      cnt_r      <= '0;
      sof_pend_r <= 1'b0;
    end else if (esc_acc_s) begin
      if (is_sof_s) begin
        cnt_r      <= '0;
        sof_pend_r <= 1'b1;
      end else begin
        cnt_r      <= cnt_r;
        sof_pend_r <= sof_pend_r;
      end
    end else if (byte_acc_s) begin
      if (cnt_r == LAST) begin
        cnt_r      <= '0;
        sof_pend_r <= 1'b0;
      end else begin
        asm_data_r[{cnt_r, 3'b000} +: 8] <= bus.i_data;
        cnt_r                            <= cnt_r + 1'b1;
      end
    end else begin
      cnt_r      <= cnt_r;
      sof_pend_r <= sof_pend_r;
    end
  end

  // Output holding register; a reload in the draining cycle keeps valid high with no bubble
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_word_r  <= '0;
      out_sof_r   <= 1'b0;
      out_valid_r <= 1'b0;
    end else if (load_s) begin
      out_word_r  <= {bus.i_data, asm_data_r};
      out_sof_r   <= sof_pend_r;
      out_valid_r <= 1'b1;
    end else if (bus.i_ready) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

`ifdef CPSTR_WORDASM_ERRCNT_EN
  logic             err_s;
  logic [ERR_W-1:0] err_cnt_r;

  // Unknown escape, or SOF that discards a partial word
  always_comb begin
    err_s = esc_acc_s && (!is_sof_s || (cnt_r != '0));
  end

  // Saturating protocol error counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt_r <= '0;
    end else if (err_s && (err_cnt_r != {ERR_W{1'b1}})) begin
      err_cnt_r <= err_cnt_r + 1'b1;
    end else begin
      err_cnt_r <= err_cnt_r;
    end
  end

  assign bus.o_err_cnt = err_cnt_r;
`else
  assign bus.o_err_cnt = '0;
`endif

  assign bus.o_ready     = ready_s;
  assign bus.o_esc_ready = 1'b1;
  assign bus.o_word      = out_word_r;
  assign bus.o_sof       = out_sof_r;
  assign bus.o_valid     = out_valid_r;

endmodule
